// File: rtl/mem_pkg.sv
// Shared encodings for the RAM responder: access sizes, FSM states and the
// alignment rule used by both the datapath and the error logic.
package mem_pkg;

  // Access size encoding, matching funct3[1:0] of RISC-V loads and stores.
  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Width of the wait-cycle counter; LATENCY is limited to 0..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // True when the access cannot be performed at this byte offset.
  // The reserved size is treated as misaligned so it is always rejected.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: extracts and extends load data from a
// storage word, and positions store data with its byte-enable mask.
module mem_align (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en
);
  import mem_pkg::*;

  logic [1:0]  lane;
  logic [4:0]  shamt;
  logic [31:0] shifted;

  // Lane selection: bytes sit at addr[1:0], halfwords at addr[1]*2, words at 0.
  always_comb begin
    lane    = 2'b00;
    byte_en = 4'b0000;
    case (size)
      SIZE_B: begin
        lane    = addr_lo;
        byte_en = 4'b0001 << addr_lo;
      end
      SIZE_H: begin
        lane    = {addr_lo[1], 1'b0};
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
      end
      SIZE_W: begin
        lane    = 2'b00;
        byte_en = 4'b1111;
      end
      default: begin
        lane    = 2'b00;
        byte_en = 4'b0000;
      end
    endcase
  end

  assign shamt      = {lane, 3'b000};
  assign shifted    = rword >> shamt;
  assign store_word = wdata << shamt;

  // Sign or zero extension of the selected lane(s).
  always_comb begin
    load_data = 32'h0;
    case (size)
      SIZE_B: begin
        if (is_unsigned) load_data = {24'h0, shifted[7:0]};
        else             load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        if (is_unsigned) load_data = {16'h0, shifted[15:0]};
        else             load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      SIZE_W:  load_data = shifted;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/ram_responder.sv
// Word-organised RAM behind a valid/ready request port with a fixed,
// parameterised response latency. One request is in flight at a time.
module ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  import mem_pkg::*;

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // LATENCY = 0 skips WAIT entirely, so the counter value is irrelevant there.
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // Request fields captured on accept and held until the response.
  logic        rw_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          req_err;
  logic [31:0]   rword;
  logic [31:0]   load_data;
  logic [31:0]   store_word;
  logic [3:0]    byte_en;

  assign idx          = addr_q[AW+1:2];
  assign out_of_range = ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
  assign req_err      = misaligned(size_q, addr_q[1:0]) || out_of_range;
  // Out-of-range reads never index the array; their data is discarded anyway.
  assign rword        = out_of_range ? 32'h0 : mem[idx];

  mem_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rword       (rword),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word),
    .byte_en     (byte_en)
  );

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 32'h0;
      size_q     <= SIZE_B;
      uns_q      <= 1'b0;
      wdata_q    <= 32'h0;
    end else begin
      // Response outputs are a one-cycle strobe; idle value is all zero.
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            rw_q      <= req_rw;
            addr_q    <= req_addr;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= (LATENCY > 0) ? StWait : StResp;
          end
        end
        StWait: begin
          if (cnt == '0) begin
            state <= StResp;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StResp: begin
          resp_valid <= 1'b1;
          resp_err   <= req_err;
          resp_rdata <= (req_err || rw_q) ? 32'h0 : load_data;
          req_ready  <= 1'b1;
          state      <= StIdle;
        end
        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Store commit on the RESP edge; reset in RESP cancels the write.
  always_ff @(posedge clk) begin
    if (!reset && state == StResp && rw_q && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed load/store cases, error
// cases, reset abort, randomized traffic and back-to-back zero-latency traffic.
module tb_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req_valid, req_ready, req_rw, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_rw, b_req_unsigned;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  ram_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  ram_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (b_req_valid),
    .req_ready    (b_req_ready),
    .req_rw       (b_req_rw),
    .req_addr     (b_req_addr),
    .req_size     (b_req_size),
    .req_unsigned (b_req_unsigned),
    .req_wdata    (b_req_wdata),
    .resp_valid   (b_resp_valid),
    .resp_rdata   (b_resp_rdata),
    .resp_err     (b_resp_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference memories for the LATENCY=2 (m2) and LATENCY=0 (m0) instances.
  logic [31:0] m2 [1024];
  logic [31:0] m0 [1024];

  // Reference behaviour: byte-addressed little-endian memory access.
  task automatic model_access(input bit which, input logic rw, input logic [31:0] addr,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] wdata, output logic err,
                              output logic [31:0] rdata);
    int unsigned widx, sh, nbytes;
    logic [31:0] word, mask, val;
    widx   = addr / 4;
    sh     = 8 * (addr % 4);
    nbytes = 1 << size;
    err = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
          (size == 2'b10 && addr % 4 != 0) || (widx >= 1024);
    rdata = 32'h0;
    if (!err) begin
      word = which ? m0[widx] : m2[widx];
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
      if (rw) begin
        word = (word & ~(mask << sh)) | ((wdata & mask) << sh);
        if (which) m0[widx] = word;
        else       m2[widx] = word;
      end else begin
        val = (word >> sh) & mask;
        if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
        rdata = val;
      end
    end
  endtask

  task automatic scramble_a();
    req_valid    = 1'($urandom % 2);
    req_rw       = 1'($urandom % 2);
    req_addr     = $urandom;
    req_size     = 2'($urandom % 4);
    req_unsigned = 1'($urandom % 2);
    req_wdata    = $urandom;
  endtask

  // One transaction on the LATENCY=2 instance, checked against the model.
  task automatic run_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input string tag);
    logic        eerr;
    logic [31:0] erd;
    int          n;
    bit          got;
    model_access(1'b0, rw, addr, size, uns, wdata, eerr, erd);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (resp_valid === 1'b1) got = 1'b1;
      else begin
        scramble_a();
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!got || n != 3) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (seen=%0b) want 3", tag, n, got);
    end
    if (got) begin
      checks++;
      if (resp_err !== eerr) begin
        errors++;
        $display("FAIL %s resp_err: got %b want %b", tag, resp_err, eerr);
      end
      checks++;
      if (resp_rdata !== erd) begin
        errors++;
        $display("FAIL %s resp_rdata: got %h want %h", tag, resp_rdata, erd);
      end
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s ready_at_resp: got %b want 1", tag, req_ready);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s strobe_end: got valid=%b rdata=%h err=%b want 0/0/0",
               tag, resp_valid, resp_rdata, resp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    b_req_valid = 1'b0; b_req_rw = 1'b0; b_req_addr = '0; b_req_size = '0;
    b_req_unsigned = 1'b0; b_req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
    checks++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got rdata=%h err=%b want 0/0", resp_rdata, resp_err);
    end
    checks++;
    if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_lat0: got ready=%b valid=%b want 1/0", b_req_ready, b_resp_valid);
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < 16; i++) run_req(1'b1, 32'(4 * i), 2'b10, 1'b0, 32'h0, "init_sw");
  endtask

  task automatic test_word();
    run_req(1'b1, 32'hC, 2'b10, 1'b0, 32'h0100_0000, "sw_c");
    checks++;
    if (dut.mem[3] !== 32'h0100_0000) begin
      errors++;
      $display("FAIL sw_c_word3: got %h want 01000000", dut.mem[3]);
    end
    run_req(1'b0, 32'hC, 2'b10, 1'b0, 32'h0, "lw_c");
  endtask

  task automatic test_byte();
    run_req(1'b1, 32'h2, 2'b00, 1'b0, 32'h0000_00FF, "sb_2");
    checks++;
    if (dut.mem[0] !== 32'h00FF_0000) begin
      errors++;
      $display("FAIL sb_2_word0: got %h want 00ff0000", dut.mem[0]);
    end
    run_req(1'b0, 32'h2, 2'b00, 1'b0, 32'h0, "lb_2");
    run_req(1'b0, 32'h2, 2'b00, 1'b1, 32'h0, "lbu_2");
  endtask

  task automatic test_half();
    run_req(1'b1, 32'h4, 2'b10, 1'b0, 32'h1234_0000, "sw_4");
    run_req(1'b1, 32'h4, 2'b01, 1'b0, 32'h0000_FFFF, "sh_4");
    checks++;
    if (dut.mem[1] !== 32'h1234_FFFF) begin
      errors++;
      $display("FAIL sh_4_word1: got %h want 1234ffff", dut.mem[1]);
    end
    run_req(1'b0, 32'h4, 2'b01, 1'b0, 32'h0, "lh_4");
  endtask

  task automatic test_errors();
    run_req(1'b1, 32'h6, 2'b10, 1'b0, 32'hDEAD_BEEF, "sw_misaligned");
    checks++;
    if (dut.mem[1] !== 32'h1234_FFFF) begin
      errors++;
      $display("FAIL sw_misaligned_word1: got %h want 1234ffff", dut.mem[1]);
    end
    run_req(1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, "lw_out_of_range");
    run_req(1'b1, 32'h8, 2'b11, 1'b0, 32'hFFFF_FFFF, "reserved_size");
    run_req(1'b0, 32'h5, 2'b01, 1'b0, 32'h0, "lh_odd");
  endtask

  // Reset in WAIT and in RESP must drop the request without any write.
  task automatic test_reset_abort();
    bit seen;
    for (int phase = 0; phase < 2; phase++) begin
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = (phase == 0) ? 32'h0 : 32'h8;
      req_wdata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (phase == 1) begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort%0d_after_reset: got ready=%b valid=%b want 1/0",
                 phase, req_ready, resp_valid);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (resp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL abort%0d_no_resp: got resp_valid=1 want 0", phase);
      end
      checks++;
      if (dut.mem[phase*2] !== m2[phase*2]) begin
        errors++;
        $display("FAIL abort%0d_mem: got %h want %h", phase, dut.mem[phase*2], m2[phase*2]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      if ($urandom % 8 == 0) a = 32'h1000 + ($urandom % 64);
      else                   a = $urandom % 64;
      run_req(1'($urandom % 2), a, 2'($urandom % 4), 1'($urandom % 2), $urandom, "rand");
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dut.mem[i] !== m2[i]) begin
        errors++;
        $display("FAIL rand_mem[%0d]: got %h want %h", i, dut.mem[i], m2[i]);
      end
    end
  endtask

  // LATENCY=0 with req_valid held high: ready alternates, no response lost.
  task automatic test_back_to_back();
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic        eerr, exp_ready, issue;
    logic [31:0] erd;
    int          accepts, resps, total, cyc;
    accepts = 0; resps = 0; total = 56; cyc = 0; exp_ready = 1'b1;
    while ((resps < total || accepts < total) && cyc < 400) begin
      @(negedge clk);
      if (b_resp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_resp: got resp at cycle %0d want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({b_resp_err, b_resp_rdata} !== e) begin
            errors++;
            $display("FAIL b2b_resp%0d: got err=%b rdata=%h want err=%b rdata=%h",
                     resps, b_resp_err, b_resp_rdata, e[32], e[31:0]);
          end
        end
        resps++;
      end
      checks++;
      if (b_req_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d: got %b want %b", cyc, b_req_ready, exp_ready);
      end
      issue = exp_ready && (accepts < total);
      if (issue) begin
        if (accepts < 16) begin
          b_req_rw = 1'b1; b_req_addr = 32'(4 * accepts); b_req_size = 2'b10;
          b_req_unsigned = 1'b0; b_req_wdata = 32'h0;
        end else begin
          b_req_rw = 1'($urandom % 2); b_req_addr = $urandom % 64;
          b_req_size = 2'($urandom % 4); b_req_unsigned = 1'($urandom % 2);
          b_req_wdata = $urandom;
        end
        b_req_valid = 1'b1;
        model_access(1'b1, b_req_rw, b_req_addr, b_req_size, b_req_unsigned, b_req_wdata,
                     eerr, erd);
        exp_q.push_back({eerr, erd});
        accepts++;
      end else if (accepts < total) begin
        b_req_rw = 1'($urandom % 2); b_req_addr = $urandom;
        b_req_size = 2'($urandom % 4); b_req_unsigned = 1'($urandom % 2);
        b_req_wdata = $urandom;
      end else begin
        b_req_valid = 1'b0;
      end
      exp_ready = !issue;
      cyc++;
    end
    b_req_valid = 1'b0;
    checks++;
    if (resps != total || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses (%0d pending) want %0d",
               resps, exp_q.size(), total);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dut0.mem[i] !== m0[i]) begin
        errors++;
        $display("FAIL b2b_mem[%0d]: got %h want %h", i, dut0.mem[i], m0[i]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
